control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/cu_pkg.sv | 115 +++++++++++
 rtl/cu_decode.sv | 88 ++++++++
 rtl/control_unit.sv | 140 ++++++++++++++
 tb/tb_control_unit.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// Shared types for the control unit: opcodes, state encoding, ALU_op and
// BusDataSelect codes, opcode classes and the opcode-to-ALU_op table.
// Optional feature macro: CU_SINGLE_STEP_EN adds the IDLE state.
package cu_pkg;

    // Opcodes, ir[31:27]
    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_BR   = 5'b10011;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    // ALU_op codes
    localparam logic [3:0] ALU_NONE = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_ROR  = 4'd5;
    localparam logic [3:0] ALU_ROL  = 4'd6;
    localparam logic [3:0] ALU_SHR  = 4'd7;
    localparam logic [3:0] ALU_SHRA = 4'd8;
    localparam logic [3:0] ALU_SHL  = 4'd9;

    // BusDataSelect codes
    localparam logic [4:0] BUS_NONE   = 5'b00000;
    localparam logic [4:0] BUS_GPR    = 5'b10000;
    localparam logic [4:0] BUS_ZLO    = 5'b10011;
    localparam logic [4:0] BUS_PC     = 5'b10100;
    localparam logic [4:0] BUS_MDR    = 5'b10101;
    localparam logic [4:0] BUS_INPORT = 5'b10110;
    localparam logic [4:0] BUS_CEXT   = 5'b10111;

    typedef enum logic [3:0] {
        ST_T0   = 4'd0,
        ST_T1   = 4'd1,
        ST_T2   = 4'd2,
        ST_T3   = 4'd3,
        ST_T4   = 4'd4,
        ST_T5   = 4'd5,
        ST_T6   = 4'd6,
        ST_T7   = 4'd7,
        ST_T8   = 4'd8,
        ST_T9   = 4'd9,
        ST_HALT = 4'd10
`ifdef CU_SINGLE_STEP_EN
        , ST_IDLE = 4'd11
`endif
    } state_t;

    typedef enum logic [3:0] {
        CL_RTYPE, CL_IMM, CL_LDI, CL_LD, CL_ST, CL_IN, CL_OUT,
        CL_BR, CL_NOP, CL_HALT, CL_ILL
    } op_class_t;

    typedef struct packed {
        logic       incPC, e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR;
        logic       e_MAR, e_GP, e_OutPort, e_InPort, e_RA, e_CON_FF;
        logic       ram_read, ram_write, MDR_read;
        logic       Gra, Grb, Grc, e_Rin, e_Rout, BAout, imm_sel;
        logic [3:0] alu_op;
        logic [4:0] bus_sel;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    function automatic op_class_t op_class(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
            OP_ROL, OP_SHR, OP_SHRA, OP_SHL:   return CL_RTYPE;
            OP_ADDI, OP_ANDI, OP_ORI:          return CL_IMM;
            OP_LDI:                            return CL_LDI;
            OP_LD:                             return CL_LD;
            OP_ST:                             return CL_ST;
            OP_IN:                             return CL_IN;
            OP_OUT:                            return CL_OUT;
            OP_BR:                             return CL_BR;
            OP_NOP:                            return CL_NOP;
            OP_HALT:                           return CL_HALT;
            default:                           return CL_ILL;
        endcase
    endfunction

    // Memory and branch instructions compute their address with an add.
    function automatic logic [3:0] alu_for_op(input logic [4:0] op);
        case (op)
            OP_ADD, OP_ADDI, OP_LD, OP_LDI, OP_ST, OP_BR: return ALU_ADD;
            OP_SUB:                                       return ALU_SUB;
            OP_AND, OP_ANDI:                              return ALU_AND;
            OP_OR, OP_ORI:                                return ALU_OR;
            OP_ROR:                                       return ALU_ROR;
            OP_ROL:                                       return ALU_ROL;
            OP_SHR:                                       return ALU_SHR;
            OP_SHRA:                                      return ALU_SHRA;
            OP_SHL:                                       return ALU_SHL;
            default:                                      return ALU_NONE;
        endcase
    endfunction

endpackage

// File: rtl/cu_decode.sv
// Combinational decode of (state, opcode, con) into the datapath control word.
// Ports: state_i current state, opcode_i ir[31:27], con_i branch condition,
//        ctrl_o packed ctrl_t control word (all zero outside named steps).
module cu_decode
    import cu_pkg::*;
(
    input  logic [3:0]        state_i,
    input  logic [4:0]        opcode_i,
    input  logic              con_i,
    output logic [CTRL_W-1:0] ctrl_o
);

    ctrl_t     c;
    op_class_t cls;

    always_comb begin
        c         = '0;
        c.bus_sel = BUS_NONE;
        cls       = op_class(opcode_i);
        case (state_t'(state_i))
            ST_T0: begin c.bus_sel = BUS_PC; c.e_MAR = 1'b1; c.incPC = 1'b1; end
            ST_T1: c.ram_read = 1'b1;
            ST_T2: begin c.MDR_read = 1'b1; c.e_MDR = 1'b1; end
            ST_T3: begin c.bus_sel = BUS_MDR; c.e_IR = 1'b1; end
            ST_T4: case (cls)
                CL_RTYPE, CL_IMM: begin
                    c.Grb = 1'b1; c.e_Rout = 1'b1; c.bus_sel = BUS_GPR; c.e_Y = 1'b1;
                end
                CL_LDI, CL_LD, CL_ST: begin
                    c.Grb = 1'b1; c.BAout = 1'b1; c.bus_sel = BUS_GPR; c.e_Y = 1'b1;
                end
                CL_IN:  c.e_InPort = 1'b1;
                CL_OUT: begin
                    c.Gra = 1'b1; c.e_Rout = 1'b1; c.bus_sel = BUS_GPR; c.e_OutPort = 1'b1;
                end
                CL_BR: begin
                    c.Gra = 1'b1; c.e_Rout = 1'b1; c.bus_sel = BUS_GPR; c.e_CON_FF = 1'b1;
                end
                default: ;
            endcase
            ST_T5: case (cls)
                CL_RTYPE: begin
                    c.Grc = 1'b1; c.e_Rout = 1'b1; c.bus_sel = BUS_GPR;
                    c.alu_op = alu_for_op(opcode_i); c.e_Z = 1'b1;
                end
                CL_IMM, CL_LDI, CL_LD, CL_ST: begin
                    c.bus_sel = BUS_CEXT; c.imm_sel = 1'b1;
                    c.alu_op = alu_for_op(opcode_i); c.e_Z = 1'b1;
                end
                CL_IN: begin c.bus_sel = BUS_INPORT; c.Gra = 1'b1; c.e_Rin = 1'b1; end
                CL_BR: begin c.bus_sel = BUS_PC; c.e_Y = 1'b1; end
                default: ;
            endcase
            ST_T6: case (cls)
                CL_RTYPE, CL_IMM, CL_LDI: begin
                    c.bus_sel = BUS_ZLO; c.Gra = 1'b1; c.e_Rin = 1'b1;
                end
                CL_LD, CL_ST: begin c.bus_sel = BUS_ZLO; c.e_MAR = 1'b1; end
                CL_BR: begin
                    c.bus_sel = BUS_CEXT; c.imm_sel = 1'b1;
                    c.alu_op = ALU_ADD; c.e_Z = 1'b1;
                end
                default: ;
            endcase
            ST_T7: case (cls)
                CL_LD: c.ram_read = 1'b1;
                // Store data goes onto the bus from Ra; MDR latches from the bus, not memory.
                CL_ST: begin
                    c.Gra = 1'b1; c.e_Rout = 1'b1; c.bus_sel = BUS_GPR; c.e_MDR = 1'b1;
                end
                CL_BR: if (con_i) begin c.e_PC = 1'b1; c.bus_sel = BUS_ZLO; end
                default: ;
            endcase
            ST_T8: case (cls)
                CL_LD: begin c.MDR_read = 1'b1; c.e_MDR = 1'b1; end
                CL_ST: c.ram_write = 1'b1;
                default: ;
            endcase
            ST_T9: if (cls == CL_LD) begin
                c.bus_sel = BUS_MDR; c.Gra = 1'b1; c.e_Rin = 1'b1;
            end
            default: ;
        endcase
    end

    assign ctrl_o = c;

endmodule

// File: rtl/control_unit.sv
// Control unit: state register and next-state logic; cu_decode drives controls.
// Ports: clock_i, clear_i (sync active-low), ir_i, con_i, [step_i], datapath
//        controls (*_o), run_o, illegal_o. Macro CU_SINGLE_STEP_EN adds step_i/IDLE.
module control_unit
    import cu_pkg::*;
(
    input  logic       clock_i,
    input  logic       clear_i,
    input  logic [31:0] ir_i,
    input  logic       con_i,
`ifdef CU_SINGLE_STEP_EN
    input  logic       step_i,
`endif
    output logic       incPC_o,
    output logic       e_PC_o,
    output logic       e_IR_o,
    output logic       e_Y_o,
    output logic       e_Z_o,
    output logic       e_HI_o,
    output logic       e_LO_o,
    output logic       e_MDR_o,
    output logic       e_MAR_o,
    output logic       e_GP_o,
    output logic       e_OutPort_o,
    output logic       e_InPort_o,
    output logic       e_RA_o,
    output logic       e_CON_FF_o,
    output logic       ram_read_o,
    output logic       ram_write_o,
    output logic       MDR_read_o,
    output logic       Gra_o,
    output logic       Grb_o,
    output logic       Grc_o,
    output logic       e_Rin_o,
    output logic       e_Rout_o,
    output logic       BAout_o,
    output logic       imm_sel_o,
    output logic [3:0] ALU_op_o,
    output logic [4:0] BusDataSelect_o,
    output logic       run_o,
    output logic       illegal_o
);

`ifdef CU_SINGLE_STEP_EN
    localparam state_t ST_DONE = ST_IDLE;
`else
    localparam state_t ST_DONE = ST_T0;
`endif

    state_t            state_q, state_d;
    logic              illegal_q, illegal_d;
    op_class_t         cls;
    logic [CTRL_W-1:0] ctrl_vec;
    ctrl_t             ctrl;
    logic              ir_unused;

    // Only the opcode field steers control; operand fields belong to the datapath.
    assign ir_unused = ^ir_i[26:0];

    always_ff @(posedge clock_i) begin
        if (!clear_i) begin
            state_q   <= ST_DONE;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        cls       = op_class(ir_i[31:27]);
        case (state_q)
            ST_T0: state_d = ST_T1;
            ST_T1: state_d = ST_T2;
            ST_T2: state_d = ST_T3;
            ST_T3: state_d = ST_T4;
            ST_T4: case (cls)
                CL_OUT, CL_NOP: state_d = ST_DONE;
                CL_HALT: begin state_d = ST_HALT; illegal_d = 1'b0; end
                CL_ILL:  begin state_d = ST_HALT; illegal_d = 1'b1; end
                default: state_d = ST_T5;
            endcase
            // From T5 on, anything not continuing (including an ir changed
            // mid-instruction) simply finishes the instruction.
            ST_T5: state_d = (cls == CL_IN) ? ST_DONE : ST_T6;
            ST_T6: state_d = (cls inside {CL_LD, CL_ST, CL_BR}) ? ST_T7 : ST_DONE;
            ST_T7: state_d = (cls inside {CL_LD, CL_ST}) ? ST_T8 : ST_DONE;
            ST_T8: state_d = (cls == CL_LD) ? ST_T9 : ST_DONE;
            ST_T9: state_d = ST_DONE;
            ST_HALT: state_d = ST_HALT;
`ifdef CU_SINGLE_STEP_EN
            ST_IDLE: if (step_i) state_d = ST_T0;
`endif
            default: state_d = ST_DONE;
        endcase
    end

    cu_decode u_decode (
        .state_i  (state_q),
        .opcode_i (ir_i[31:27]),
        .con_i    (con_i),
        .ctrl_o   (ctrl_vec)
    );

    // Holding clear low silences every control immediately, not just after the edge.
    assign ctrl = clear_i ? ctrl_t'(ctrl_vec) : '0;

    assign incPC_o         = ctrl.incPC;
    assign e_PC_o          = ctrl.e_PC;
    assign e_IR_o          = ctrl.e_IR;
    assign e_Y_o           = ctrl.e_Y;
    assign e_Z_o           = ctrl.e_Z;
    assign e_HI_o          = ctrl.e_HI;
    assign e_LO_o          = ctrl.e_LO;
    assign e_MDR_o         = ctrl.e_MDR;
    assign e_MAR_o         = ctrl.e_MAR;
    assign e_GP_o          = ctrl.e_GP;
    assign e_OutPort_o     = ctrl.e_OutPort;
    assign e_InPort_o      = ctrl.e_InPort;
    assign e_RA_o          = ctrl.e_RA;
    assign e_CON_FF_o      = ctrl.e_CON_FF;
    assign ram_read_o      = ctrl.ram_read;
    assign ram_write_o     = ctrl.ram_write;
    assign MDR_read_o      = ctrl.MDR_read;
    assign Gra_o           = ctrl.Gra;
    assign Grb_o           = ctrl.Grb;
    assign Grc_o           = ctrl.Grc;
    assign e_Rin_o         = ctrl.e_Rin;
    assign e_Rout_o        = ctrl.e_Rout;
    assign BAout_o         = ctrl.BAout;
    assign imm_sel_o       = ctrl.imm_sel;
    assign ALU_op_o        = ctrl.alu_op;
    assign BusDataSelect_o = ctrl.bus_sel;

    assign run_o     = clear_i && (state_q != ST_HALT);
    assign illegal_o = clear_i && (state_q == ST_HALT) && illegal_q;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: per-instruction expected control
// sequences are built from the instruction descriptions and compared cycle by cycle.
module tb_control_unit;

    typedef struct packed {
        logic incPC, e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR;
        logic e_MAR, e_GP, e_OutPort, e_InPort, e_RA, e_CON_FF;
        logic ram_read, ram_write, MDR_read;
        logic Gra, Grb, Grc, e_Rin, e_Rout, BAout, imm_sel;
        logic [3:0] alu;
        logic [4:0] bus;
        logic run, illegal;
    } cw_t;

    localparam logic [4:0] B_GPR = 5'b10000, B_ZLO = 5'b10011, B_PC = 5'b10100;
    localparam logic [4:0] B_MDR = 5'b10101, B_INP = 5'b10110, B_CEXT = 5'b10111;

    logic clock = 1'b0, clear = 1'b0, con = 1'b0;
    logic [31:0] ir = 32'd0;
`ifdef CU_SINGLE_STEP_EN
    logic step = 1'b0;
`endif
    logic incPC, e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR, e_GP, e_OutPort;
    logic e_InPort, e_RA, e_CON_FF, ram_read, ram_write, MDR_read, Gra, Grb, Grc;
    logic e_Rin, e_Rout, BAout, imm_sel, run, illegal;
    logic [3:0] ALU_op;
    logic [4:0] BusDataSelect;
    cw_t obs;

    int total = 0, bad = 0;
    cw_t exp_q[$];

    always #5 clock = ~clock;

    control_unit dut (
        .clock_i(clock), .clear_i(clear), .ir_i(ir), .con_i(con),
`ifdef CU_SINGLE_STEP_EN
        .step_i(step),
`endif
        .incPC_o(incPC), .e_PC_o(e_PC), .e_IR_o(e_IR), .e_Y_o(e_Y), .e_Z_o(e_Z),
        .e_HI_o(e_HI), .e_LO_o(e_LO), .e_MDR_o(e_MDR), .e_MAR_o(e_MAR), .e_GP_o(e_GP),
        .e_OutPort_o(e_OutPort), .e_InPort_o(e_InPort), .e_RA_o(e_RA),
        .e_CON_FF_o(e_CON_FF), .ram_read_o(ram_read), .ram_write_o(ram_write),
        .MDR_read_o(MDR_read), .Gra_o(Gra), .Grb_o(Grb), .Grc_o(Grc), .e_Rin_o(e_Rin),
        .e_Rout_o(e_Rout), .BAout_o(BAout), .imm_sel_o(imm_sel), .ALU_op_o(ALU_op),
        .BusDataSelect_o(BusDataSelect), .run_o(run), .illegal_o(illegal)
    );

    assign obs = {incPC, e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR, e_GP, e_OutPort,
                  e_InPort, e_RA, e_CON_FF, ram_read, ram_write, MDR_read, Gra, Grb, Grc,
                  e_Rin, e_Rout, BAout, imm_sel, ALU_op, BusDataSelect, run, illegal};

    // ---------------- reference model ----------------
    function automatic cw_t nil();
        cw_t c = '0;
        c.run = 1'b1;
        return c;
    endfunction

    function automatic cw_t fetch0();
        cw_t c = nil();
        c.bus = B_PC; c.e_MAR = 1'b1; c.incPC = 1'b1;
        return c;
    endfunction

    function automatic cw_t after_reset();
`ifdef CU_SINGLE_STEP_EN
        return nil();
`else
        return fetch0();
`endif
    endfunction

    function automatic bit runs_normally(input logic [4:0] op);
        return (op <= 5'd14) || op == 5'd19 || op == 5'd22 || op == 5'd23 || op == 5'd26;
    endfunction

    // ALU_op table: R-type opcodes 3..11 map to codes 1..9 in order; immediates reuse add/and/or.
    function automatic logic [3:0] alu_of(input logic [4:0] op);
        if (op >= 5'd3 && op <= 5'd11) return 4'(op - 5'd2);
        if (op == 5'd12) return 4'd1;
        if (op == 5'd13) return 4'd3;
        if (op == 5'd14) return 4'd4;
        return 4'd1;
    endfunction

    task automatic build_seq(input logic [4:0] op, input logic c_in);
        cw_t c;
        exp_q.delete();
        exp_q.push_back(fetch0());
        c = nil(); c.ram_read = 1;                     exp_q.push_back(c);
        c = nil(); c.MDR_read = 1; c.e_MDR = 1;        exp_q.push_back(c);
        c = nil(); c.bus = B_MDR; c.e_IR = 1;          exp_q.push_back(c);
        if (op >= 5'd3 && op <= 5'd14) begin
            c = nil(); c.Grb = 1; c.e_Rout = 1; c.bus = B_GPR; c.e_Y = 1; exp_q.push_back(c);
            c = nil(); c.alu = alu_of(op); c.e_Z = 1;
            if (op <= 5'd11) begin c.Grc = 1; c.e_Rout = 1; c.bus = B_GPR; end
            else begin c.bus = B_CEXT; c.imm_sel = 1; end
            exp_q.push_back(c);
            c = nil(); c.bus = B_ZLO; c.Gra = 1; c.e_Rin = 1; exp_q.push_back(c);
        end else if (op <= 5'd2) begin
            c = nil(); c.Grb = 1; c.BAout = 1; c.bus = B_GPR; c.e_Y = 1; exp_q.push_back(c);
            c = nil(); c.bus = B_CEXT; c.imm_sel = 1; c.alu = 4'd1; c.e_Z = 1; exp_q.push_back(c);
            c = nil(); c.bus = B_ZLO;
            if (op == 5'd1) begin c.Gra = 1; c.e_Rin = 1; end else c.e_MAR = 1;
            exp_q.push_back(c);
            if (op == 5'd0) begin
                c = nil(); c.ram_read = 1;                         exp_q.push_back(c);
                c = nil(); c.MDR_read = 1; c.e_MDR = 1;            exp_q.push_back(c);
                c = nil(); c.bus = B_MDR; c.Gra = 1; c.e_Rin = 1;  exp_q.push_back(c);
            end else if (op == 5'd2) begin
                c = nil(); c.Gra = 1; c.e_Rout = 1; c.bus = B_GPR; c.e_MDR = 1; exp_q.push_back(c);
                c = nil(); c.ram_write = 1; exp_q.push_back(c);
            end
        end else if (op == 5'd22) begin
            c = nil(); c.e_InPort = 1; exp_q.push_back(c);
            c = nil(); c.bus = B_INP; c.Gra = 1; c.e_Rin = 1; exp_q.push_back(c);
        end else if (op == 5'd23) begin
            c = nil(); c.Gra = 1; c.e_Rout = 1; c.bus = B_GPR; c.e_OutPort = 1; exp_q.push_back(c);
        end else if (op == 5'd19) begin
            c = nil(); c.Gra = 1; c.e_Rout = 1; c.bus = B_GPR; c.e_CON_FF = 1; exp_q.push_back(c);
            c = nil(); c.bus = B_PC; c.e_Y = 1; exp_q.push_back(c);
            c = nil(); c.bus = B_CEXT; c.imm_sel = 1; c.alu = 4'd1; c.e_Z = 1; exp_q.push_back(c);
            c = nil(); if (c_in) begin c.e_PC = 1; c.bus = B_ZLO; end exp_q.push_back(c);
        end else begin
            exp_q.push_back(nil());   // nop, halt, unsupported: T4 drives nothing
        end
    endtask

    // ---------------- stimulus ----------------
    task automatic step_pulse();
`ifdef CU_SINGLE_STEP_EN
        step = 1'b1; @(posedge clock); #1; step = 1'b0;
`endif
    endtask

    task automatic do_reset();
        clear = 1'b0; @(posedge clock); #1;
        clear = 1'b1;
        step_pulse();
    endtask

    // Runs one instruction from T0 with garbage on ir/con during fetch.
    // stop_at >= 0 returns at the start of that step instead of finishing.
    task automatic run_instr(input logic [31:0] instr, input logic c_in, input string nm,
                             input bit halts, input int stop_at);
        int n;
        build_seq(instr[31:27], c_in);
        n = (stop_at >= 0) ? stop_at : exp_q.size();
        for (int k = 0; k < n; k++) begin
            ir  = (k < 4) ? $urandom : instr;
            con = (k < 4) ? 1'($urandom) : c_in;
            #1;
            total++;
            if (obs !== exp_q[k]) begin
                bad++;
                $display("FAIL %s step%0d got=%h want=%h", nm, k, obs, exp_q[k]);
            end
            @(posedge clock); #1;
        end
`ifdef CU_SINGLE_STEP_EN
        if (!halts && stop_at < 0) begin
            for (int k = 0; k < 2; k++) begin
                total++;
                if (obs !== nil()) begin
                    bad++;
                    $display("FAIL %s idle%0d got=%h want=%h", nm, k, obs, nil());
                end
                @(posedge clock); #1;
            end
            step_pulse();
        end
`endif
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        clear = 1'b0;
        for (int k = 0; k < 2; k++) begin
            ir = $urandom; con = 1'($urandom);
            @(posedge clock); #1;
            total++;
            if (obs !== cw_t'(0)) begin
                bad++; $display("FAIL reset_held%0d got=%h want=0", k, obs);
            end
        end
        clear = 1'b1; #1;
        total++;
        if (obs !== after_reset()) begin
            bad++; $display("FAIL reset_release got=%h want=%h", obs, after_reset());
        end
        step_pulse();
        total++;
        if (obs !== fetch0()) begin
            bad++; $display("FAIL reset_t0 got=%h want=%h", obs, fetch0());
        end
    endtask

    task automatic test_in();
        run_instr(32'hB1800000, 1'b0, "in_r3", 0, -1);
    endtask

    task automatic test_add();
        run_instr(32'h1A900000, 1'b0, "add", 0, -1);
        #1;
        total++;
        if (obs !== fetch0()) begin
            bad++; $display("FAIL add_next_t0 got=%h want=%h", obs, fetch0());
        end
    endtask

    task automatic test_branch();
        run_instr(32'h99000004, 1'b0, "br_con0", 0, -1);
        run_instr(32'h99000004, 1'b1, "br_con1", 0, -1);
    endtask

    task automatic test_store();
        run_instr(32'h10880087, 1'b0, "st", 0, -1);
    endtask

    task automatic test_back_to_back();
        logic [4:0] op;
        for (int i = 0; i < 40; i++) begin
            op = 5'd26;
            for (int t = 0; t < 64; t++) begin
                op = 5'($urandom_range(0, 31));
                if (runs_normally(op)) break;
                op = 5'd26;
            end
            run_instr({op, 27'($urandom)}, 1'($urandom), "random", 0, -1);
        end
    endtask

    task automatic test_halt(input logic [31:0] instr, input logic want_ill, input string nm);
        cw_t h;
        h = '0; h.illegal = want_ill;
        run_instr(instr, 1'b0, nm, 1, -1);
        for (int k = 0; k < 10; k++) begin
            ir = $urandom; con = 1'($urandom);
`ifdef CU_SINGLE_STEP_EN
            step = 1'b1;
`endif
            #1;
            total++;
            if (obs !== h) begin
                bad++; $display("FAIL %s halt%0d got=%h want=%h", nm, k, obs, h);
            end
            @(posedge clock); #1;
        end
`ifdef CU_SINGLE_STEP_EN
        step = 1'b0;
`endif
        clear = 1'b0; @(posedge clock); #1; clear = 1'b1; #1;
        total++;
        if (obs !== after_reset()) begin
            bad++; $display("FAIL %s exit got=%h want=%h", nm, obs, after_reset());
        end
        step_pulse();
    endtask

    task automatic test_clear_mid();
        logic [31:0] instr;
        instr = {5'b00000, 27'($urandom)};
        run_instr(instr, 1'b0, "ld_pre", 0, 7);
        clear = 1'b0; #1;
        total++;
        if (obs !== cw_t'(0)) begin
            bad++; $display("FAIL clear_mid_held got=%h want=0", obs);
        end
        @(posedge clock); #1; clear = 1'b1; #1;
        total++;
        if (obs !== after_reset()) begin
            bad++; $display("FAIL clear_mid_next got=%h want=%h", obs, after_reset());
        end
        step_pulse();
        run_instr(32'hD0000000, 1'b0, "nop_after", 0, -1);
    endtask

    initial begin
        logic [4:0] bad_op;
        test_reset();
        test_in();
        test_add();
        test_branch();
        test_store();
        test_back_to_back();
        test_halt(32'hF8000000, 1'b1, "illegal_f8");
        test_halt(32'hD8000000, 1'b0, "halt_op");
        bad_op = 5'd31;
        for (int t = 0; t < 64; t++) begin
            bad_op = 5'($urandom_range(0, 31));
            if (!runs_normally(bad_op) && bad_op != 5'd27) break;
            bad_op = 5'd31;
        end
        test_halt({bad_op, 27'($urandom)}, 1'b1, "illegal_rand");
        test_clear_mid();
        do_reset();
        run_instr(32'h08800010, 1'b0, "ldi_after_reset", 0, -1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
